// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters, registered renderer coordinates, and a
// latency-matched sync/blank pipeline so vga_hs/vs land with the renderer's RGB.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 72,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 200,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 22,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b1,
  parameter int PIX_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pix_r,
  input  logic [3:0]  pix_g,
  input  logic [3:0]  pix_b,
  output logic [10:0] curr_x,
  output logic [9:0]  curr_y,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Stages between the counter and the output register: renderer latency plus
  // the coordinate register that feeds the renderer.
  localparam int DEPTH   = PIX_LAT + 1;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_reg;
  logic [9:0]  v_cnt_reg;
  logic        de_raw;
  logic        hs_raw;
  logic        vs_raw;
  logic [2:0]  sync_pipe_reg [DEPTH];
  logic [2:0]  sync_tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      if (v_cnt_reg == V_LAST) begin
        v_cnt_reg <= '0;
      end else begin
        v_cnt_reg <= v_cnt_reg + 10'd1;
      end
    end else begin
      h_cnt_reg <= h_cnt_reg + 11'd1;
    end
  end

  assign de_raw = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
  assign hs_raw = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign vs_raw = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);

  // Coordinates are zeroed in blanking so the renderer never indexes past its tile map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curr_x      <= '0;
      curr_y      <= '0;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      curr_x      <= de_raw ? h_cnt_reg : 11'd0;
      curr_y      <= de_raw ? v_cnt_reg : 10'd0;
      active      <= de_raw;
      line_start  <= de_raw && (h_cnt_reg == 11'd0);
      frame_start <= de_raw && (h_cnt_reg == 11'd0) && (v_cnt_reg == 10'd0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sync_pipe
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_pipe_reg[gi] <= 3'b000;
        end else if (gi == 0) begin
          sync_pipe_reg[gi] <= {de_raw, hs_raw, vs_raw};
        end else begin
          sync_pipe_reg[gi] <= sync_pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign sync_tail = sync_pipe_reg[DEPTH-1];

  // sync_tail lines up with the renderer's pix_* for the same raster position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= ~H_POL;
      vga_vs <= ~V_POL;
    end else begin
      vga_r  <= sync_tail[2] ? pix_r : 4'd0;
      vga_g  <= sync_tail[2] ? pix_g : 4'd0;
      vga_b  <= sync_tail[2] ? pix_b : 4'd0;
      vga_hs <= sync_tail[1] ? H_POL : ~H_POL;
      vga_vs <= sync_tail[0] ? V_POL : ~V_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: two instances (PIX_LAT 1 and 3)
// with stub renderers, a scoreboard on every cycle, and directed timing measurements.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = 9;
  localparam int LAT_A = 1, LAT_B = 3;
  localparam int LIMIT = 400;

  typedef struct packed {logic [10:0] x; logic [9:0] y; logic act, ls, fs;} s1_t;
  typedef struct packed {logic hs, vs; logic [3:0] r, g, b;} vo_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  pr_a, pg_a, pb_a, r_a, g_a, b_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        act_a, ls_a, fs_a, hs_a, vs_a;
  logic [3:0]  pr_b, pg_b, pb_b, r_b, g_b, b_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;
  logic        act_b, ls_b, fs_b, hs_b, vs_b;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .pix_r(pr_a), .pix_g(pg_a), .pix_b(pb_a),
    .curr_x(x_a), .curr_y(y_a), .active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .pix_r(pr_b), .pix_g(pg_b), .pix_b(pb_b),
    .curr_x(x_b), .curr_y(y_b), .active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b));

  // Stub renderers: colour = {x[3:0], y[3:0], F}, delayed PIX_LAT cycles.
  logic [11:0] stub_a [LAT_A];
  logic [11:0] stub_b [LAT_B];
  always @(posedge clk) begin
    stub_a[0] <= {x_a[3:0], y_a[3:0], 4'hF};
    for (int i = 1; i < LAT_A; i++) stub_a[i] <= stub_a[i-1];
    stub_b[0] <= {x_b[3:0], y_b[3:0], 4'hF};
    for (int i = 1; i < LAT_B; i++) stub_b[i] <= stub_b[i-1];
  end
  assign {pr_a, pg_a, pb_a} = stub_a[LAT_A-1];
  assign {pr_b, pg_b, pb_b} = stub_b[LAT_B-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected outputs for raster position (h,v); sync levels are H_POL=0, V_POL=1.
  function automatic void expect_at(input int h, input int v, output s1_t s, output vo_t o);
    bit a;
    a    = (h < HA) && (v < VA);
    s.x  = a ? 11'(h) : 11'd0;
    s.y  = a ? 10'(v) : 10'd0;
    s.act = a;
    s.ls = a && (h == 0);
    s.fs = a && (h == 0) && (v == 0);
    o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs = (v >= VA + VF) && (v < VA + VF + VS);
    o.r  = a ? 4'(h) : 4'h0;
    o.g  = a ? 4'(v) : 4'h0;
    o.b  = a ? 4'hF : 4'h0;
  endfunction

  s1_t q_s1[$];
  vo_t q_a[$];
  vo_t q_b[$];
  bit  started = 1'b0;

  // Reference raster: one expected entry per rising edge after reset release.
  initial begin
    int mh, mv;
    s1_t s;
    vo_t o, blank;
    mh = 0;
    mv = 0;
    blank = {1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mh = 0;
        mv = 0;
        q_s1.delete();
        q_a.delete();
        q_b.delete();
        started = 1'b0;
      end else begin
        if (!started) begin
          for (int i = 0; i < LAT_A + 1; i++) q_a.push_back(blank);
          for (int i = 0; i < LAT_B + 1; i++) q_b.push_back(blank);
          started = 1'b1;
        end
        expect_at(mh, mv, s, o);
        q_s1.push_back(s);
        q_a.push_back(o);
        q_b.push_back(o);
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  end

  // Monitor: reset state while held/pre-first-edge, otherwise pop and compare.
  initial begin
    s1_t es;
    vo_t ea, eb;
    forever begin
      @(negedge clk);
      if (!rst || !started) begin
        chk("rst_s1_a", {x_a, y_a, act_a, ls_a, fs_a}, 32'h0);
        chk("rst_vga_a", {hs_a, vs_a, r_a, g_a, b_a}, 32'h2000);
        chk("rst_vga_b", {hs_b, vs_b, r_b, g_b, b_b}, 32'h2000);
      end else if (q_s1.size() == 0 || q_a.size() == 0 || q_b.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_underflow: got empty queue, expected pending entry");
      end else begin
        es = q_s1.pop_front();
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("s1_a", {x_a, y_a, act_a, ls_a, fs_a}, 32'(es));
        chk("s1_b", {x_b, y_b, act_b, ls_b, fs_b}, 32'(es));
        chk("vga_a", {hs_a, vs_a, r_a, g_a, b_a}, 32'(ea));
        chk("vga_b", {hs_b, vs_b, r_b, g_b, b_b}, 32'(eb));
        if (es.ls) $display("line y=%0d start, %0d/%0d so far", es.y, pass_cnt, total_cnt);
      end
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0: return hs_a;
      1: return vs_a;
      2: return fs_a;
      3: return act_a;
      4: return b_a != 4'h0;
      5: return hs_b;
      6: return b_b != 4'h0;
      default: return 1'b0;
    endcase
  endfunction

  // Width of the next run at level lvl, and distance to the following run start.
  task automatic measure(input int sel, input bit lvl, output int width, output int period);
    bit prev, cur, found;
    int w, p;
    width = -1;
    period = -1;
    found = 1'b0;
    prev = sig(sel);
    for (int i = 0; i < LIMIT && !found; i++) begin
      @(negedge clk);
      cur = sig(sel);
      found = (cur == lvl) && (prev != lvl);
      prev = cur;
    end
    if (!found) return;
    w = 1;
    found = 1'b0;
    for (int i = 0; i < LIMIT && !found; i++) begin
      @(negedge clk);
      if (sig(sel) == lvl) w++;
      else found = 1'b1;
    end
    if (!found) return;
    width = w;
    p = w + 1;
    found = 1'b0;
    for (int i = 0; i < LIMIT && !found; i++) begin
      @(negedge clk);
      if (sig(sel) == lvl) found = 1'b1;
      else p++;
    end
    if (found) period = p;
  endtask

  // Samples from the first blank sample after a pixel run to the first hsync-low sample.
  task automatic gap_to_hs(input int sel_b, input int sel_hs, output int gap);
    bit prev, cur, found;
    int n;
    gap = -1;
    found = 1'b0;
    prev = sig(sel_b);
    for (int i = 0; i < LIMIT && !found; i++) begin
      @(negedge clk);
      cur = sig(sel_b);
      found = prev && !cur;
      prev = cur;
    end
    if (!found) return;
    n = 0;
    found = !sig(sel_hs);
    for (int i = 0; i < LIMIT && !found; i++) begin
      @(negedge clk);
      n++;
      found = !sig(sel_hs);
    end
    if (found) gap = n;
  endtask

  initial begin
    int w, p, n, first;
    bit hit;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_hs_a", 32'(hs_a), 32'h1);
    chk("reset_vs_a", 32'(vs_a), 32'h0);
    chk("reset_fs_a", 32'(fs_a), 32'h0);

    @(posedge clk);
    #2 rst = 1'b1;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      @(negedge clk);
      n++;
      hit = fs_a;
    end
    chk("fs_latency", 32'(n), 32'd2);

    measure(0, 1'b0, w, p);
    chk("hs_low_width", 32'(w), 32'(HS));
    chk("hs_period", 32'(p), 32'(HT));
    measure(3, 1'b1, w, p);
    chk("active_width", 32'(w), 32'(HA));
    measure(4, 1'b1, w, p);
    chk("b_run_width_a", 32'(w), 32'(HA));
    gap_to_hs(4, 0, n);
    chk("b_end_to_hs_a", 32'(n), 32'(HF));
    measure(1, 1'b1, w, p);
    chk("vs_high_width", 32'(w), 32'(VS * HT));
    chk("vs_period", 32'(p), 32'(VT * HT));
    measure(2, 1'b1, w, p);
    chk("fs_width", 32'(w), 32'd1);
    chk("fs_period", 32'(p), 32'(VT * HT));
    measure(5, 1'b0, w, p);
    chk("hs_low_width_b", 32'(w), 32'(HS));
    chk("hs_period_b", 32'(p), 32'(HT));
    measure(6, 1'b1, w, p);
    chk("b_run_width_b", 32'(w), 32'(HA));
    gap_to_hs(6, 5, n);
    chk("b_end_to_hs_b", 32'(n), 32'(HF));

    // Mid-frame reset at raster (4,2), asserted away from any clock edge.
    hit = 1'b0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      @(negedge clk);
      hit = (x_a == 11'd4) && (y_a == 10'd2);
    end
    chk("midframe_reached", 32'(hit), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_s1_a", {x_a, y_a, act_a, ls_a, fs_a}, 32'h0);
    chk("async_vga_a", {hs_a, vs_a, r_a, g_a, b_a}, 32'h2000);
    chk("async_vga_b", {hs_b, vs_b, r_b, g_b, b_b}, 32'h2000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    first = 0;
    for (int i = 0; i < LIMIT && first == 0; i++) begin
      @(negedge clk);
      if (fs_a) first = 1;
      else if (vs_a) first = 2;
    end
    chk("fs_before_vs", 32'(first), 32'd1);

    repeat (2 * VT * HT) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
